// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC/NPC, req/ack fetch into a one-word buffer, IR load on ir_en strobe.
// Zero-wait fetch fills the buffer two edges after a PC update; ir_en on an empty buffer stalls via fetch_busy.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_en,
    input  logic        pc_sel,
    input  logic        npc_en,
    input  logic        ir_en,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] npc,
    output logic [31:0] ir,
    output logic [5:0]  opcode,
    output logic [10:0] alu_funcode,
    output logic        fetch_busy,
    output logic        fault
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_REQ
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] npc_q, npc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] buf_q, buf_d;
    logic        buf_vld_q, buf_vld_d;
    logic [31:0] addr_q, addr_d;
    logic        req_q, req_d;
    logic        pend_q, pend_d;
    logic        drop_q, drop_d;
    logic        fault_q, fault_d;

    logic        rsp_accept;
    logic        launch_bad;
    logic        fill;
    logic [31:0] fill_word;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        npc_d     = npc_en ? pc_q + 32'd4 : npc_q;
        ir_d      = ir_q;
        buf_d     = buf_q;
        buf_vld_d = buf_vld_q;
        addr_d    = addr_q;
        req_d     = req_q;
        pend_d    = pend_q;
        drop_d    = drop_q;
        fault_d   = fault_q;

        // A redirect in the same cycle as an ack discards the response.
        rsp_accept = req_q && imem_ack && !drop_q && !pc_en;
        launch_bad = (state_q == ST_LAUNCH) && !pc_en && (pc_q[1:0] != 2'b00);
        fill       = rsp_accept || launch_bad;
        fill_word  = launch_bad ? 32'h0000_0000 : imem_rdata;

        case (state_q)
            ST_IDLE: begin
            end
            ST_LAUNCH: begin
                if (launch_bad) begin
                    fault_d   = 1'b1;
                    buf_d     = 32'h0000_0000;
                    buf_vld_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (imem_ack) begin
                    req_d  = 1'b0;
                    drop_d = 1'b0;
                    if (drop_q) begin
                        state_d = ST_LAUNCH;
                    end else begin
                        buf_d     = imem_rdata;
                        buf_vld_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_LAUNCH;
        endcase

        if (pc_en) begin
            pc_d      = pc_sel ? branch_target : npc_q;
            buf_vld_d = 1'b0;
            // Requests are never retracted: keep the old address up and drop its data.
            if ((state_q == ST_REQ) && !imem_ack) begin
                drop_d = 1'b1;
            end else begin
                req_d   = 1'b0;
                state_d = ST_LAUNCH;
            end
        end

        if (ir_en && buf_vld_q) begin
            ir_d = buf_q;
        end else if ((ir_en || pend_q) && fill) begin
            ir_d   = fill_word;
            pend_d = 1'b0;
        end else if (ir_en) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_LAUNCH;
            pc_q      <= RESET_PC;
            npc_q     <= RESET_PC + 32'd4;
            ir_q      <= 32'h0000_0000;
            buf_q     <= 32'h0000_0000;
            buf_vld_q <= 1'b0;
            addr_q    <= RESET_PC;
            req_q     <= 1'b0;
            pend_q    <= 1'b0;
            drop_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            npc_q     <= npc_d;
            ir_q      <= ir_d;
            buf_q     <= buf_d;
            buf_vld_q <= buf_vld_d;
            addr_q    <= addr_d;
            req_q     <= req_d;
            pend_q    <= pend_d;
            drop_q    <= drop_d;
            fault_q   <= fault_d;
        end
    end

    assign imem_addr   = addr_q;
    assign imem_req    = req_q;
    assign pc          = pc_q;
    assign npc         = npc_q;
    assign ir          = ir_q;
    assign opcode      = ir_q[31:26];
    assign alu_funcode = ir_q[10:0];
    assign fetch_busy  = pend_q;
    assign fault       = fault_q;

endmodule
